// File: rtl/opram_pkg.sv
// Shared encodings, FSM state type and lane-count helper for the opram_sp RAM.
// Optional parity (macro OPRAM_SP_PARITY_EN) is handled in the interface and top.
package opram_pkg;

  localparam int RD_BYPASS  = 0;
  localparam int RD_PIPE    = 1;

  localparam int WR_NORMAL  = 0;
  localparam int WR_THROUGH = 1;
  localparam int WR_RBW     = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } opram_state_e;

  function automatic int nlane(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/opram_sp_if.sv
// Access bus of opram_sp; the master drives requests, the slave returns read data.
// Handshake: a request is taken on any edge where ce=1 and busy=0; rvalid=1 marks dout as data from a completed access.
interface opram_sp_if
  import opram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LANE_W = 8
);
  localparam int NLANE = nlane(DATA_W, LANE_W);

  logic              ce;
  logic              oce;
  logic              srst;
  logic              wre;
  logic [NLANE-1:0]  be;
  logic [ADDR_W-1:0] ad;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rvalid;
  logic              busy;
`ifdef OPRAM_SP_PARITY_EN
  logic [NLANE-1:0]  perr;
`endif

  modport master (
    output ce, oce, srst, wre, be, ad, din,
`ifdef OPRAM_SP_PARITY_EN
    input  perr,
`endif
    input  dout, rvalid, busy
  );

  modport slave (
    input  ce, oce, srst, wre, be, ad, din,
`ifdef OPRAM_SP_PARITY_EN
    output perr,
`endif
    output dout, rvalid, busy
  );

endinterface

// File: rtl/opram_sp_clr.sv
// Post-reset zero-fill sequencer: walks every address once, then parks in ST_READY.
module opram_sp_clr
  import opram_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              fill_we,
  output logic              busy,
  output opram_state_e      state
);

  localparam opram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic         RST_BUSY  = (CLEAR_ON_RESET != 0);

  opram_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (&addr_q) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      busy_q  <= RST_BUSY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  assign fill_addr = addr_q;
  assign fill_we   = (state_q == ST_CLEAR);
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: rtl/opram_sp.sv
// Parametrised single-port RAM with byte lanes, write-read modes, optional output register and zero-fill.
// Define OPRAM_SP_PARITY_EN to add per-lane even parity storage and the perr output.
module opram_sp
  import opram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int LANE_W         = 8,
  parameter int READ_MODE      = 0,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  opram_sp_if.slave    bus,
  output opram_state_e dbg_state
);

  localparam int NLANE = nlane(DATA_W, LANE_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_we;
  logic              busy;
  logic              acc;
  logic              rd_upd;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              dval_q, dval_d;
  logic              oval_q, oval_d;
  logic              rvalid;

  opram_sp_clr #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk       (clk),
    .reset_n   (reset_n),
    .fill_addr (fill_addr),
    .fill_we   (fill_we),
    .busy      (busy),
    .state     (dbg_state)
  );

  assign acc      = bus.ce & ~busy;
  assign old_word = mem[bus.ad];
  assign rd_upd   = acc & (~bus.wre | (WRITE_MODE != WR_NORMAL));

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NLANE; i++) begin
      if (bus.be[i]) merged[i*LANE_W +: LANE_W] = bus.din[i*LANE_W +: LANE_W];
    end
  end

  // Fill owns the port while busy; a full merged word is written so disabled lanes keep old data.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= '0;
    end else if (acc && bus.wre) begin
      mem[bus.ad] <= merged;
    end
  end

  always_comb begin
    data_d = data_q;
    if (acc) begin
      if (!bus.wre || (WRITE_MODE == WR_RBW)) begin
        data_d = old_word;
      end else if (WRITE_MODE == WR_THROUGH) begin
        data_d = merged;
      end
    end
    // In pipelined mode a staged result waits for oce; otherwise validity lasts one cycle.
    if (rd_upd) begin
      dval_d = 1'b1;
    end else if ((READ_MODE == RD_PIPE) && !bus.oce) begin
      dval_d = dval_q;
    end else begin
      dval_d = 1'b0;
    end
    out_d  = bus.oce ? data_q : out_q;
    oval_d = bus.oce ? dval_q : oval_q;
    if (bus.srst) begin
      data_d = '0;
      dval_d = 1'b0;
      out_d  = '0;
      oval_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      dval_q <= 1'b0;
      out_q  <= '0;
      oval_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dval_q <= dval_d;
      out_q  <= out_d;
      oval_q <= oval_d;
    end
  end

  assign rvalid     = (READ_MODE == RD_PIPE) ? oval_q : dval_q;
  assign bus.rvalid = rvalid;
  assign bus.dout   = (READ_MODE == RD_PIPE) ? out_q : data_q;
  assign bus.busy   = busy;

`ifdef OPRAM_SP_PARITY_EN
  logic [NLANE-1:0] par [DEPTH];
  logic [NLANE-1:0] old_par;
  logic [NLANE-1:0] new_par;
  logic [NLANE-1:0] chk;
  logic [NLANE-1:0] perr_q, perr_d;
  logic [NLANE-1:0] operr_q, operr_d;

  assign old_par = par[bus.ad];

  always_comb begin
    new_par = '0;
    chk     = '0;
    for (int i = 0; i < NLANE; i++) begin
      new_par[i] = ^merged[i*LANE_W +: LANE_W];
      chk[i]     = (^old_word[i*LANE_W +: LANE_W]) ^ old_par[i];
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      par[fill_addr] <= '0;
    end else if (acc && bus.wre) begin
      par[bus.ad] <= new_par;
    end
  end

  // Error flags travel with the data they describe; write-through words are fresh, hence clean.
  always_comb begin
    perr_d = perr_q;
    if (acc) begin
      if (!bus.wre || (WRITE_MODE == WR_RBW)) begin
        perr_d = chk;
      end else if (WRITE_MODE == WR_THROUGH) begin
        perr_d = '0;
      end
    end
    operr_d = bus.oce ? perr_q : operr_q;
    if (bus.srst) begin
      perr_d  = '0;
      operr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q  <= '0;
      operr_q <= '0;
    end else begin
      perr_q  <= perr_d;
      operr_q <= operr_d;
    end
  end

  assign bus.perr = rvalid ? ((READ_MODE == RD_PIPE) ? operr_q : perr_q) : '0;
`endif

endmodule

// File: tb/tb_opram_sp.sv
// Self-checking bench for opram_sp: three configurations (default, 32-bit pipelined write-through, read-before-write without fill).
`timescale 1ns/1ps
module tb_opram_sp;
  import opram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a;
  logic rst_bc;

  int checks = 0;
  int errors = 0;

  opram_sp_if #(.DATA_W(8),  .ADDR_W(8), .LANE_W(8)) ifa ();
  opram_sp_if #(.DATA_W(32), .ADDR_W(6), .LANE_W(8)) ifb ();
  opram_sp_if #(.DATA_W(8),  .ADDR_W(4), .LANE_W(8)) ifc ();

  opram_state_e st_a, st_b, st_c;

  opram_sp #(.DATA_W(8), .ADDR_W(8), .LANE_W(8), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .reset_n(rst_a), .bus(ifa), .dbg_state(st_a));
  opram_sp #(.DATA_W(32), .ADDR_W(6), .LANE_W(8), .READ_MODE(1), .WRITE_MODE(1), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .reset_n(rst_bc), .bus(ifb), .dbg_state(st_b));
  opram_sp #(.DATA_W(8), .ADDR_W(4), .LANE_W(8), .READ_MODE(0), .WRITE_MODE(2), .CLEAR_ON_RESET(0))
    dut_c (.clk(clk), .reset_n(rst_bc), .bus(ifc), .dbg_state(st_c));

  // ---------------- scoreboards ----------------
  logic [7:0]  exp_a[$];
  logic [31:0] exp_b[$];
  logic [7:0]  exp_c[$];
  logic [7:0]  mdl_a [256];
  logic [31:0] mdl_b [64];
  logic        b_mon = 1'b0;

  always @(negedge clk) begin
    if (ifa.rvalid !== 1'b0) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_rvalid got rvalid=%b dout=%0h expected no output", ifa.rvalid, ifa.dout);
      end else begin
        automatic logic [7:0] e = exp_a.pop_front();
        if (ifa.dout !== e) begin
          errors++;
          $display("FAIL a_read_data got %0h expected %0h", ifa.dout, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_mon && ifb.rvalid !== 1'b0) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_rvalid got rvalid=%b dout=%0h expected no output", ifb.rvalid, ifb.dout);
      end else begin
        automatic logic [31:0] e = exp_b.pop_front();
        if (ifb.dout !== e) begin
          errors++;
          $display("FAIL b_read_data got %0h expected %0h", ifb.dout, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_op(input logic ce, input logic wre, input logic [7:0] ad,
                      input logic [7:0] din, input logic be, input logic srst);
    ifa.ce = ce; ifa.wre = wre; ifa.ad = ad; ifa.din = din; ifa.be = be; ifa.srst = srst; ifa.oce = 1'b0;
    if (ce && !wre && !srst) exp_a.push_back(mdl_a[ad]);
    if (ce && wre && be) mdl_a[ad] = din;
    @(negedge clk);
  endtask

  task automatic b_op(input logic ce, input logic wre, input logic [3:0] be,
                      input logic [5:0] ad, input logic [31:0] din);
    logic [31:0] w;
    ifb.ce = ce; ifb.wre = wre; ifb.be = be; ifb.ad = ad; ifb.din = din; ifb.oce = 1'b1; ifb.srst = 1'b0;
    if (ce) begin
      w = mdl_b[ad];
      if (wre) begin
        for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = din[i*8 +: 8];
        mdl_b[ad] = w;
      end
      exp_b.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic c_step(input logic ce, input logic wre, input logic be, input logic [3:0] ad,
                        input logic [7:0] din, input logic srst, input logic exp_rv,
                        input logic chk_d, input logic [7:0] exp_d, input string name);
    logic [7:0] e;
    ifc.ce = ce; ifc.wre = wre; ifc.be = be; ifc.ad = ad; ifc.din = din; ifc.srst = srst; ifc.oce = 1'b0;
    exp_c.push_back(exp_d);
    @(negedge clk);
    e = exp_c.pop_front();
    checks++;
    if (ifc.rvalid !== exp_rv) begin
      errors++;
      $display("FAIL %s_rvalid got %b expected %b", name, ifc.rvalid, exp_rv);
    end
    if (chk_d) begin
      checks++;
      if (ifc.dout !== e) begin
        errors++;
        $display("FAIL %s_dout got %0h expected %0h", name, ifc.dout, e);
      end
    end
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    while (ifa.busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (ifa.busy !== 1'b1 || ifa.rvalid !== 1'b0 || ifa.dout !== 8'h00 || st_a !== ST_CLEAR) begin
      errors++;
      $display("FAIL reset_a got busy=%b rvalid=%b dout=%0h state=%0d expected 1 0 0 %0d",
               ifa.busy, ifa.rvalid, ifa.dout, st_a, ST_CLEAR);
    end
    checks++;
    if (ifb.busy !== 1'b1 || ifb.rvalid !== 1'b0 || ifb.dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_b got busy=%b rvalid=%b dout=%0h expected 1 0 0", ifb.busy, ifb.rvalid, ifb.dout);
    end
    checks++;
    if (ifc.busy !== 1'b0 || ifc.rvalid !== 1'b0 || ifc.dout !== 8'h00 || st_c !== ST_READY) begin
      errors++;
      $display("FAIL reset_c got busy=%b rvalid=%b dout=%0h state=%0d expected 0 0 0 %0d",
               ifc.busy, ifc.rvalid, ifc.dout, st_c, ST_READY);
    end
  endtask

  task automatic test_fill_count();
    int n;
    @(negedge clk);
    rst_a = 1'b1;
    rst_bc = 1'b1;
    count_busy_a(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL fill_cycles got %0d expected 256", n);
    end
  endtask

  task automatic test_read_after_fill();
    a_op(1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ifa.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency got rvalid=%b expected 1", ifa.rvalid);
    end
    a_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ifa.rvalid !== 1'b0 || ifa.dout !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_read got rvalid=%b dout=%0h expected 0 0", ifa.rvalid, ifa.dout);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) a_op(1'b1, 1'b1, 8'(8'hE0 + i), 8'(8'h30 + 3 * i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) a_op(1'b1, 1'b0, 8'(8'hE7 - i), 8'h00, 1'b0, 1'b0);
    a_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random_a();
    for (int i = 0; i < 80; i++) begin
      a_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end
    a_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    a_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_srst();
    a_op(1'b1, 1'b1, 8'h07, 8'hC3, 1'b1, 1'b1);
    checks++;
    if (ifa.rvalid !== 1'b0 || ifa.dout !== 8'h00) begin
      errors++;
      $display("FAIL srst_write got rvalid=%b dout=%0h expected 0 0", ifa.rvalid, ifa.dout);
    end
    a_op(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    a_op(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ifa.rvalid !== 1'b0 || ifa.dout !== 8'h00) begin
      errors++;
      $display("FAIL srst_read got rvalid=%b dout=%0h expected 0 0", ifa.rvalid, ifa.dout);
    end
    a_op(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    a_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL a_drain got %0d pending expected 0", exp_a.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    rst_a = 1'b0;
    for (int i = 0; i < 256; i++) mdl_a[i] = 8'h00;
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 101; i++) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    n = 0;
    while (ifa.busy === 1'b1 && n < 1000) begin
      ifa.ce = (n == 200); ifa.wre = 1'b1; ifa.be = 1'b1; ifa.ad = 8'h03; ifa.din = 8'hFF;
      checks++;
      if (ifa.dout !== 8'h00) begin
        errors++;
        $display("FAIL busy_dout got %0h expected 0", ifa.dout);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL refill_cycles got %0d expected 256", n);
    end
    a_op(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0);
    a_op(1'b1, 1'b0, 8'h64, 8'h00, 1'b0, 1'b0);
    a_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_byte_lanes();
    int n = 0;
    while (ifb.busy !== 1'b0 && n < 500) begin n++; @(negedge clk); end
    checks++;
    if (ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL b_fill_timeout got busy=%b expected 0", ifb.busy);
    end
    for (int i = 0; i < 64; i++) mdl_b[i] = 32'h0;
    b_mon = 1'b1;
    b_op(1'b1, 1'b1, 4'hF, 6'h10, 32'h11223344);
    b_op(1'b1, 1'b1, 4'b0101, 6'h10, 32'hAABBCCDD);
    b_op(1'b1, 1'b0, 4'h0, 6'h10, 32'h0);
    b_op(1'b0, 1'b0, 4'h0, 6'h00, 32'h0);
    checks++;
    if (ifb.dout !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_merge got %0h expected 11bb33dd", ifb.dout);
    end
    b_op(1'b0, 1'b0, 4'h0, 6'h00, 32'h0);
  endtask

  task automatic test_write_through();
    b_op(1'b1, 1'b1, 4'hF, 6'h03, 32'h5A);
    b_op(1'b1, 1'b1, 4'hF, 6'h03, 32'hA5);
    b_op(1'b1, 1'b0, 4'h0, 6'h03, 32'h0);
    checks++;
    if (ifb.dout !== 32'hA5 || ifb.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_through got dout=%0h rvalid=%b expected a5 1", ifb.dout, ifb.rvalid);
    end
    b_op(1'b1, 1'b1, 4'h0, 6'h03, 32'hFFFF);
    b_op(1'b0, 1'b0, 4'h0, 6'h00, 32'h0);
  endtask

  task automatic test_random_b();
    for (int i = 0; i < 40; i++) begin
      b_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           6'($urandom_range(0, 7)), 32'($urandom));
    end
    b_op(1'b1, 1'b1, 4'hF, 6'h20, 32'h77);
    b_op(1'b1, 1'b1, 4'hF, 6'h21, 32'h21);
    for (int i = 0; i < 3; i++) b_op(1'b0, 1'b0, 4'h0, 6'h00, 32'h0);
    checks++;
    if (exp_b.size() != 0) begin
      errors++;
      $display("FAIL b_drain got %0d pending expected 0", exp_b.size());
    end
    b_mon = 1'b0;
  endtask

  task automatic b_expect(input logic [31:0] d, input logic v, input string name);
    checks++;
    if (ifb.dout !== d || ifb.rvalid !== v) begin
      errors++;
      $display("FAIL %s got dout=%0h rvalid=%b expected %0h %b", name, ifb.dout, ifb.rvalid, d, v);
    end
  endtask

  task automatic test_oce_hold();
    ifb.ce = 1'b1; ifb.wre = 1'b0; ifb.ad = 6'h20; ifb.oce = 1'b1;
    @(negedge clk);
    ifb.ce = 1'b0;
    @(negedge clk);
    b_expect(32'h77, 1'b1, "pipe_latency2");
    ifb.ce = 1'b1; ifb.ad = 6'h21; ifb.oce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_expect(32'h77, 1'b1, "oce_hold");
    end
    ifb.ce = 1'b0; ifb.oce = 1'b1;
    @(negedge clk);
    b_expect(32'h21, 1'b1, "oce_release");
    @(negedge clk);
    checks++;
    if (ifb.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL pipe_rvalid_drop got %b expected 0", ifb.rvalid);
    end
  endtask

  task automatic test_read_before_write();
    c_step(1, 1, 1, 4'h3, 8'h5A, 0, 1'b1, 1'b0, 8'h00, "rbw_first");
    c_step(1, 1, 1, 4'h3, 8'hA5, 0, 1'b1, 1'b1, 8'h5A, "rbw_old");
    c_step(1, 0, 0, 4'h3, 8'h00, 0, 1'b1, 1'b1, 8'hA5, "rbw_readback");
    c_step(1, 1, 0, 4'h3, 8'hFF, 0, 1'b1, 1'b1, 8'hA5, "be0_write");
    c_step(1, 0, 0, 4'h3, 8'h00, 0, 1'b1, 1'b1, 8'hA5, "be0_readback");
    c_step(0, 0, 0, 4'h0, 8'h00, 0, 1'b0, 1'b1, 8'hA5, "ce0_hold");
  endtask

  task automatic test_srst_c();
    c_step(1, 0, 0, 4'h3, 8'h00, 1, 1'b0, 1'b1, 8'h00, "c_srst_read");
    c_step(1, 1, 1, 4'h4, 8'h3C, 1, 1'b0, 1'b1, 8'h00, "c_srst_write");
    c_step(1, 0, 0, 4'h4, 8'h00, 0, 1'b1, 1'b1, 8'h3C, "c_srst_readback");
    c_step(0, 0, 0, 4'h0, 8'h00, 0, 1'b0, 1'b1, 8'h3C, "c_idle");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_a = 1'b1;
    rst_bc = 1'b1;
    ifa.ce = 0; ifa.oce = 0; ifa.srst = 0; ifa.wre = 0; ifa.be = '0; ifa.ad = '0; ifa.din = '0;
    ifb.ce = 0; ifb.oce = 0; ifb.srst = 0; ifb.wre = 0; ifb.be = '0; ifb.ad = '0; ifb.din = '0;
    ifc.ce = 0; ifc.oce = 0; ifc.srst = 0; ifc.wre = 0; ifc.be = '0; ifc.ad = '0; ifc.din = '0;
    for (int i = 0; i < 256; i++) mdl_a[i] = 8'h00;
    #1;
    rst_a = 1'b0;
    rst_bc = 1'b0;
    test_reset();
    test_fill_count();
    test_read_after_fill();
    test_back_to_back();
    test_random_a();
    test_srst();
    test_reset_mid_fill();
    test_byte_lanes();
    test_write_through();
    test_random_b();
    test_oce_hold();
    test_read_before_write();
    test_srst_c();
    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL a_final_drain got %0d pending expected 0", exp_a.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opram_sp.md
Name: opram_sp

Overview:
- Parametrised single-port synchronous RAM and the successor to the fixed 256x8 operand RAM.
- Adds configurable width and depth, byte-lane write enables, selectable write-read behaviour and an optional output pipeline register.
- Includes a read-valid flag and a post-reset zero-fill sequencer, so the core sees deterministic contents without a software clear loop.
- Sits between the core datapath and operand storage; inferred memory only, no vendor primitive.

Parameters:
- DATA_W, 8: data word width in bits; must be a multiple of LANE_W.
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W words.
- LANE_W, 8: bits per byte-enable lane; NLANE = DATA_W/LANE_W.
- READ_MODE, 0: 0 = bypass, read latency 1; 1 = pipelined, latency 2 through an output register gated by oce.
- WRITE_MODE, 0: 0 = normal, dout holds on write; 1 = write-through; 2 = read-before-write.
- CLEAR_ON_RESET, 1: 1 = zero-fill all words after reset release; 0 = no fill.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  access enable; ignored while busy=1.
- oce  in  1  output register enable; used only when READ_MODE=1.
- srst  in  1  synchronous output clear; clears read registers and rvalid, never memory.
- wre  in  1  1 = write, 0 = read (qualified by ce).
- be  in  NLANE  per-lane write enable; lane i covers din[i*LANE_W +: LANE_W].
- ad  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data.
- rvalid  out  1  dout holds data from a completed access this cycle.
- busy  out  1  zero-fill in progress.

Behaviour:
- Async reset: dout=0, rvalid=0, internal data register=0, fill address=0, busy = CLEAR_ON_RESET.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR writes 0 to the word at the fill address each cycle, then increments the fill address.
  - After writing DEPTH-1, CLEAR goes to READY; busy drops in the cycle following the last fill write.
  - The fill takes exactly DEPTH cycles after the first clk edge with reset_n=1.
  - While busy=1, ce/wre/be are ignored, rvalid stays 0 and dout stays 0.
- Accepted access: ce=1 and busy=0.
- Read (wre=0): the data register loads mem[ad] at the edge.
  - READ_MODE=0: dout = data register; rvalid=1 in the following cycle (latency 1).
  - READ_MODE=1: the output register loads the data register, and rvalid follows, on each edge with oce=1; data arrives at latency 2 with oce held 1.
  - With oce=0 the output register and rvalid hold, and the data register stages the newest read.
- Write (wre=1): each lane with be[i]=1 is written; lanes with be[i]=0 keep their old contents.
  - be=0 with wre=1 is a no-op write.
  - Data-register effect: WRITE_MODE 0: holds, and the write sets no rvalid. WRITE_MODE 1: loads the merged new word (new enabled lanes, old disabled lanes), with rvalid as for a read. WRITE_MODE 2: loads the old word, with rvalid as for a read.
- ce=0: no memory change; the data register holds; rvalid drops to 0 in READ_MODE 0.
  - In READ_MODE 1 the output stage still follows oce; its rvalid input is 0 when no access was staged.
- srst=1: data register, output register and rvalid go to 0 at the edge. srst has priority over a same-cycle read update; a same-cycle write to memory still occurs.
- Back-to-back accesses are allowed every cycle; there is no collision hazard (single port).
- reset_n asserted mid-fill: the fill address returns to 0 and the fill restarts fully after release.
- Memory contents are not reset by reset_n when CLEAR_ON_RESET=0.
- Address wrap: none needed; all ADDR_W values are valid.

Optional Feature:
- Macro: OPRAM_SP_PARITY_EN.
- Defined:
  - Each word stores NLANE extra even-parity bits, computed per lane on write.
  - Zero-fill stores parity 0 for each zero lane.
  - Output port perr[NLANE-1:0] is added. It is registered alongside dout with the same latency and is qualified by rvalid (0 when rvalid=0).
  - perr[i]=1 when lane i fails its check.
  - Write-through words are computed fresh, so they report perr=0.
- Undefined: no parity storage and no perr port.

Decomposition:
- Shared package opram_pkg holds:
  - READ_MODE encodings RD_BYPASS=0, RD_PIPE=1.
  - WRITE_MODE encodings WR_NORMAL=0, WR_THROUGH=1, WR_RBW=2.
  - The FSM state enum ST_CLEAR/ST_READY.
  - A function computing NLANE.
- Sub-module opram_sp_clr: the zero-fill sequencer, outputting fill address, fill write strobe and busy.

Test Plan:
- Reset then release, defaults: busy=1 for exactly 256 cycles; then read 0x55 -> dout=0x00, rvalid=1 one cycle later.
- DATA_W=32, LANE_W=8: write 0x11223344 to 0x10 with be=4'hF, then write 0xAABBCCDD with be=4'b0101; read 0x10 -> 0x11BB33DD.
- WRITE_MODE=2: mem[3]=0x5A; write 0xA5 to 3 -> dout=0x5A next cycle; read 3 -> 0xA5. WRITE_MODE=1 with the same stimulus -> dout=0xA5 right after the write.
- READ_MODE=1: read 0x20 (holds 0x77) with oce=1 -> dout=0x77 and rvalid at edge+2. oce=0 for 3 cycles while reading 0x21 -> dout holds 0x77; raise oce -> 0x21 data appears.
- srst during a read: read issued with srst=1 -> dout=0, rvalid=0. Write with srst=1 -> memory updated, verified by a later read.
- reset_n pulsed at fill address 100 -> busy restarts and lasts 256 full cycles. ce=1 writes during busy -> no effect; word still 0 after the fill.
